// File: rtl/bundle_pkg.sv
// Shared types and constants for the bundling (majority-vote) controller.
// BUNDLE_TIEBREAK_LFSR_EN selects LFSR tie-breaking in bundle_ctrl.
package bundle_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCUM  = 3'd1,
      DRAIN  = 3'd2,
      THRESH = 3'd3,
      OUT    = 3'd4
   } state_t;

   localparam logic signed [1:0] SEL_PLUS  = 2'sb01;
   localparam logic signed [1:0] SEL_MINUS = 2'sb11;
   localparam logic signed [1:0] SEL_ZERO  = 2'sb00;

   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic signed [1:0] vote_sel(input logic store, input logic b);
      if (!store) return SEL_ZERO;
      return b ? SEL_MINUS : SEL_PLUS;
   endfunction

endpackage

// File: rtl/bundle_lane.sv
// One bundling lane: registered vote, saturating signed accumulator and
// threshold register with tie-break input.
module bundle_lane
   import bundle_pkg::*;
#(
   parameter int ACC_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic vote_load,
   input  logic vote_bit,
   input  logic store,
   input  logic thresh,
   input  logic tie_bit,
   output logic out_bit,
   output logic sat
);

   localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

   logic signed [1:0]       vote_q;
   logic signed [ACC_W-1:0] acc;

   // Votes are only ever +1/-1, so a clamp is exactly "at the limit and pushing outward"
   assign sat = ((acc == POS_LIM) && (vote_q == SEL_PLUS)) ||
                ((acc == NEG_LIM) && (vote_q == SEL_MINUS));

   always_ff @(posedge clk) begin
      if (rst) begin
         vote_q  <= SEL_ZERO;
         acc     <= '0;
         out_bit <= 1'b0;
      end else begin
         if (clr || !vote_load) vote_q <= SEL_ZERO;
         else                   vote_q <= vote_sel(store, vote_bit);

         if (clr)      acc <= '0;
         else if (!sat) acc <= acc + {{(ACC_W-2){vote_q[1]}}, vote_q};

         if (thresh) out_bit <= acc[ACC_W-1] | ((acc == '0) & tie_bit);
      end
   end

endmodule

// File: rtl/bundle_ctrl.sv
// Bundling pass sequencer: FSM, word counter, handshakes and LANES lane instances.
// Define BUNDLE_TIEBREAK_LFSR_EN to break accumulator ties with a free-running LFSR.
module bundle_ctrl
   import bundle_pkg::*;
#(
   parameter int LANES = 32,
   parameter int ACC_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] item_count,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LANES-1:0] in_word,
   input  logic             in_store,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] out_word,
   output logic             busy,
   output logic             err_sat,
   output state_t           dbg_state
);

   // Handshake: a word moves when valid & ready are both high at a rising clk edge;
   // a source holds valid and data stable until that edge, ready never depends on valid.
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             xfer;
   logic             clr;
   logic             thresh_en;
   logic [LANES-1:0] lane_sat;
   logic [LANES-1:0] tie_bits;

   assign xfer      = in_valid & in_ready;
   assign clr       = (state == IDLE) & start & (item_count != '0);
   assign thresh_en = (state == THRESH);
   assign cnt_nxt   = cnt + CNT_W'(1);
   assign busy      = (state != IDLE);
   assign dbg_state = state;

`ifdef BUNDLE_TIEBREAK_LFSR_EN
   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
   end
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef BUNDLE_TIEBREAK_LFSR_EN
      assign tie_bits[i] = lfsr[i % LFSR_W];
`else
      assign tie_bits[i] = 1'b0;
`endif
      bundle_lane #(.ACC_W(ACC_W)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .clr       (clr),
         .vote_load (xfer),
         .vote_bit  (in_word[i]),
         .store     (in_store),
         .thresh    (thresh_en),
         .tie_bit   (tie_bits[i]),
         .out_bit   (out_word[i]),
         .sat       (lane_sat[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         count_q   <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         err_sat   <= 1'b0;
      end else begin
         if (|lane_sat) err_sat <= 1'b1;
         case (state)
            IDLE: begin
               if (clr) begin
                  count_q  <= item_count;
                  cnt      <= '0;
                  err_sat  <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == count_q) begin
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN:  state <= THRESH;
            THRESH: begin
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
